uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receive shift register (RSR).
- Captures each completed frame (data byte plus framing-error flag) on the RSR's stop-bit strobe and holds it in a small FIFO.
- Presents the oldest entry as RCREG with its FERR bit, raises the receive interrupt strobe while data is pending, and tracks overrun (OERR).
- Gates further reception while OERR is set or the receiver is disabled.

---
 rtl/uart_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer behind the UART receive shift register. Each completed
//   frame (byte + framing error) is captured on the RSR stop-bit strobe into a
//   small circular FIFO. The oldest entry is shown on RCREG/FERR. Overrun is
//   tracked in OERR, which also blocks further reception.
//
//   Optional build macro: UART_RX_NINTH_BIT_EN
//     When defined, each entry also carries the 9th received bit, which is
//     written from rsr_rx9d_in and shown on rx9d_out.
//
// Ports
//   clk              system clock
//   rst              synchronous active-high reset
//   spen             serial port enable; low flushes the receiver
//   cren             continuous receive enable; low clears OERR
//   rsr_data_in      assembled byte from the RSR
//   rsr_ferr_in      framing error for the frame being pushed
//   rsr_rx9d_in      9th data bit (UART_RX_NINTH_BIT_EN only)
//   rsr_valid        one-cycle frame-complete strobe
//   rcreg_reg_rd_en  CPU read of RCREG; pops the head entry
//   rcreg_reg_out    head data byte, 0 when empty
//   ferr_out         head framing error, 0 when empty
//   rx9d_out         head 9th bit, 0 when empty (UART_RX_NINTH_BIT_EN only)
//   oerr_out         overrun error flag
//   rx_enable_out    RSR may receive: spen & cren & ~oerr
//   rxif_set_en      high while the FIFO holds data
//   count_out        current occupancy

module uart_rx_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spen,
  input  logic             cren,
  input  logic [7:0]       rsr_data_in,
  input  logic             rsr_ferr_in,
`ifdef UART_RX_NINTH_BIT_EN
  input  logic             rsr_rx9d_in,
`endif
  input  logic             rsr_valid,
  input  logic             rcreg_reg_rd_en,
  output logic [7:0]       rcreg_reg_out,
  output logic             ferr_out,
`ifdef UART_RX_NINTH_BIT_EN
  output logic             rx9d_out,
`endif
  output logic             oerr_out,
  output logic             rx_enable_out,
  output logic             rxif_set_en,
  output logic [CNT_W-1:0] count_out
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef UART_RX_NINTH_BIT_EN
  localparam int ENT_W = 10;  // {rx9d, ferr, data}
`else
  localparam int ENT_W = 9;   // {ferr, data}
`endif
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             oerr_q, oerr_d;

  logic             not_empty;
  logic             full;
  logic             push_req;
  logic             pop;
  logic             push;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef UART_RX_NINTH_BIT_EN
  assign wr_entry = {rsr_rx9d_in, rsr_ferr_in, rsr_data_in};
`else
  assign wr_entry = {rsr_ferr_in, rsr_data_in};
`endif

  assign not_empty     = (count_q != '0);
  assign full          = (count_q == FULL_CNT);
  assign rx_enable_out = spen & cren & ~oerr_q;
  assign push_req      = rsr_valid & rx_enable_out;
  assign pop           = rcreg_reg_rd_en & not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push          = push_req & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    oerr_d   = oerr_q;
    if (!spen) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      oerr_d   = 1'b0;
    end else begin
      if (!cren) oerr_d = 1'b0;
      // Clear before write: when full, wr_ptr == rd_ptr and the push must win.
      if (pop) begin
        mem_d[rd_ptr_q] = '0;
        rd_ptr_d        = ptr_inc(rd_ptr_q);
      end
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else if (push_req) begin
        // Only reachable when full with no pop: overrun, byte discarded.
        oerr_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      oerr_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      oerr_q   <= oerr_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rcreg_reg_out = not_empty ? head[7:0] : 8'h00;
  assign ferr_out      = not_empty & head[8];
`ifdef UART_RX_NINTH_BIT_EN
  assign rx9d_out      = not_empty & head[9];
`endif
  assign oerr_out      = oerr_q;
  assign rxif_set_en   = not_empty;
  assign count_out     = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             spen;
  logic             cren;
  logic [7:0]       rsr_data_in;
  logic             rsr_ferr_in;
  logic             rsr_valid;
  logic             rcreg_reg_rd_en;
  logic [7:0]       rcreg_reg_out;
  logic             ferr_out;
  logic             oerr_out;
  logic             rx_enable_out;
  logic             rxif_set_en;
  logic [CNT_W-1:0] count_out;
`ifdef UART_RX_NINTH_BIT_EN
  logic             rsr_rx9d_in;
  logic             rx9d_out;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .spen            (spen),
    .cren            (cren),
    .rsr_data_in     (rsr_data_in),
    .rsr_ferr_in     (rsr_ferr_in),
`ifdef UART_RX_NINTH_BIT_EN
    .rsr_rx9d_in     (rsr_rx9d_in),
`endif
    .rsr_valid       (rsr_valid),
    .rcreg_reg_rd_en (rcreg_reg_rd_en),
    .rcreg_reg_out   (rcreg_reg_out),
    .ferr_out        (ferr_out),
`ifdef UART_RX_NINTH_BIT_EN
    .rx9d_out        (rx9d_out),
`endif
    .oerr_out        (oerr_out),
    .rx_enable_out   (rx_enable_out),
    .rxif_set_en     (rxif_set_en),
    .count_out       (count_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb [$];   // expected {ferr, data}, oldest first
  logic [8:0] exp_e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [7:0] d, input logic f);
    rsr_data_in = d;
    rsr_ferr_in = f;
    rsr_valid   = 1'b1;
    tick();
    rsr_valid   = 1'b0;
  endtask

  task automatic drive_read();
    rcreg_reg_rd_en = 1'b1;
    tick();
    rcreg_reg_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; spen = 1'b1; cren = 1'b1;
    rsr_data_in = 8'h00; rsr_ferr_in = 1'b0; rsr_valid = 1'b0; rcreg_reg_rd_en = 1'b0;
`ifdef UART_RX_NINTH_BIT_EN
    rsr_rx9d_in = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (rcreg_reg_out !== 8'h00) begin errors++; $display("FAIL reset_rcreg: got %h expected 00", rcreg_reg_out); end
    checks++; if (ferr_out !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr_out); end
    checks++; if (oerr_out !== 1'b0) begin errors++; $display("FAIL reset_oerr: got %b expected 0", oerr_out); end
    checks++; if (rxif_set_en !== 1'b0) begin errors++; $display("FAIL reset_rxif: got %b expected 0", rxif_set_en); end
    checks++; if (rx_enable_out !== 1'b1) begin errors++; $display("FAIL reset_rxen: got %b expected 1", rx_enable_out); end
    checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
  endtask

  task automatic test_single();
    drive_push(8'hCA, 1'b0);
    sb.push_back({1'b0, 8'hCA});
    checks++; if (rcreg_reg_out !== sb[0][7:0]) begin errors++; $display("FAIL single_head: got %h expected %h", rcreg_reg_out, sb[0][7:0]); end
    checks++; if (rxif_set_en !== 1'b1) begin errors++; $display("FAIL single_rxif: got %b expected 1", rxif_set_en); end
    checks++; if (count_out !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count_out); end
    // Head and rxif must hold during the read cycle itself.
    rcreg_reg_rd_en = 1'b1;
    #1;
    exp_e = sb.pop_front();
    checks++; if (rcreg_reg_out !== exp_e[7:0] || rxif_set_en !== 1'b1) begin errors++; $display("FAIL single_readcycle: got %h/%b expected %h/1", rcreg_reg_out, rxif_set_en, exp_e[7:0]); end
    tick();
    rcreg_reg_rd_en = 1'b0;
    checks++; if (rcreg_reg_out !== 8'h00 || rxif_set_en !== 1'b0) begin errors++; $display("FAIL single_after: got %h/%b expected 00/0", rcreg_reg_out, rxif_set_en); end
    drive_read();
    checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", count_out); end
  endtask

  task automatic test_overrun();
    drive_push(8'h11, 1'b1); sb.push_back({1'b1, 8'h11});
    drive_push(8'h22, 1'b0); sb.push_back({1'b0, 8'h22});
    drive_push(8'h33, 1'b0);   // full: discarded
    checks++; if (oerr_out !== 1'b1) begin errors++; $display("FAIL ovr_oerr: got %b expected 1", oerr_out); end
    checks++; if (rx_enable_out !== 1'b0) begin errors++; $display("FAIL ovr_rxen: got %b expected 0", rx_enable_out); end
    checks++; if (count_out !== 4'd2) begin errors++; $display("FAIL ovr_count: got %0d expected 2", count_out); end
    drive_push(8'h44, 1'b0);   // ignored while oerr
    for (int i = 0; i < 2; i++) begin
      exp_e = sb.pop_front();
      checks++; if (rcreg_reg_out !== exp_e[7:0] || ferr_out !== exp_e[8]) begin errors++; $display("FAIL ovr_read%0d: got %h/%b expected %h/%b", i, rcreg_reg_out, ferr_out, exp_e[7:0], exp_e[8]); end
      drive_read();
    end
    checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL ovr_drain_count: got %0d expected 0", count_out); end
  endtask

  task automatic test_oerr_clear();
    cren = 1'b0;
    tick();
    checks++; if (oerr_out !== 1'b0 || count_out !== 4'd0) begin errors++; $display("FAIL clr_oerr: got %b/%0d expected 0/0", oerr_out, count_out); end
    drive_push(8'h66, 1'b0);   // cren low: ignored
    checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL clr_cren_push: got %0d expected 0", count_out); end
    cren = 1'b1;
    #1;
    checks++; if (rx_enable_out !== 1'b1) begin errors++; $display("FAIL clr_rxen: got %b expected 1", rx_enable_out); end
    drive_push(8'h55, 1'b0); sb.push_back({1'b0, 8'h55});
    checks++; if (rcreg_reg_out !== sb[0][7:0]) begin errors++; $display("FAIL clr_push: got %h expected %h", rcreg_reg_out, sb[0][7:0]); end
    // Overrun again while holding data, then clear: contents must survive.
    drive_push(8'h56, 1'b1); sb.push_back({1'b1, 8'h56});
    drive_push(8'h57, 1'b0);
    cren = 1'b0;
    tick();
    checks++; if (oerr_out !== 1'b0 || count_out !== 4'd2) begin errors++; $display("FAIL clr_retain: got %b/%0d expected 0/2", oerr_out, count_out); end
    cren = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_e = sb.pop_front();
      checks++; if (rcreg_reg_out !== exp_e[7:0] || ferr_out !== exp_e[8]) begin errors++; $display("FAIL clr_read%0d: got %h/%b expected %h/%b", i, rcreg_reg_out, ferr_out, exp_e[7:0], exp_e[8]); end
      drive_read();
    end
  endtask

  task automatic test_back_to_back();
    drive_push(8'hA1, 1'b0); sb.push_back({1'b0, 8'hA1});
    drive_push(8'hA2, 1'b0); sb.push_back({1'b0, 8'hA2});
    // Full plus simultaneous push/pop: no overrun.
    rsr_data_in = 8'hA3; rsr_ferr_in = 1'b0; rsr_valid = 1'b1; rcreg_reg_rd_en = 1'b1;
    exp_e = sb.pop_front();
    checks++; if (rcreg_reg_out !== exp_e[7:0]) begin errors++; $display("FAIL b2b_head: got %h expected %h", rcreg_reg_out, exp_e[7:0]); end
    sb.push_back({1'b0, 8'hA3});
    tick();
    rsr_valid = 1'b0; rcreg_reg_rd_en = 1'b0;
    checks++; if (oerr_out !== 1'b0 || count_out !== 4'd2) begin errors++; $display("FAIL b2b_full: got %b/%0d expected 0/2", oerr_out, count_out); end
    exp_e = sb.pop_front();
    checks++; if (rcreg_reg_out !== exp_e[7:0]) begin errors++; $display("FAIL b2b_read: got %h expected %h", rcreg_reg_out, exp_e[7:0]); end
    drive_read();
    // Five simultaneous push/pop pairs walk both pointers around the ring.
    for (int i = 0; i < 5; i++) begin
      rsr_data_in = 8'hB0 + 8'(i); rsr_ferr_in = 1'(i & 1); rsr_valid = 1'b1; rcreg_reg_rd_en = 1'b1;
      exp_e = sb.pop_front();
      checks++; if (rcreg_reg_out !== exp_e[7:0] || ferr_out !== exp_e[8]) begin errors++; $display("FAIL wrap_head%0d: got %h/%b expected %h/%b", i, rcreg_reg_out, ferr_out, exp_e[7:0], exp_e[8]); end
      sb.push_back({1'(i & 1), 8'hB0 + 8'(i)});
      tick();
      rsr_valid = 1'b0; rcreg_reg_rd_en = 1'b0;
      checks++; if (count_out !== 4'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 1", i, count_out); end
    end
    exp_e = sb.pop_front();
    checks++; if (rcreg_reg_out !== exp_e[7:0] || ferr_out !== exp_e[8]) begin errors++; $display("FAIL wrap_last: got %h/%b expected %h/%b", rcreg_reg_out, ferr_out, exp_e[7:0], exp_e[8]); end
    drive_read();
    checks++; if (count_out !== 4'd0 || rcreg_reg_out !== 8'h00) begin errors++; $display("FAIL wrap_empty: got %0d/%h expected 0/00", count_out, rcreg_reg_out); end
  endtask

  task automatic test_flush();
    drive_push(8'h77, 1'b1); sb.push_back({1'b1, 8'h77});
    spen = 1'b0;
    tick();
    spen = 1'b1;
    sb.delete();
    checks++; if (count_out !== 4'd0 || rcreg_reg_out !== 8'h00 || rxif_set_en !== 1'b0 || ferr_out !== 1'b0) begin errors++; $display("FAIL flush: got cnt=%0d rc=%h rxif=%b ferr=%b expected 0/00/0/0", count_out, rcreg_reg_out, rxif_set_en, ferr_out); end
`ifdef UART_RX_NINTH_BIT_EN
    rsr_rx9d_in = 1'b1;
    drive_push(8'h01, 1'b0);
    rsr_rx9d_in = 1'b0;
    checks++; if (rx9d_out !== 1'b1 || rcreg_reg_out !== 8'h01) begin errors++; $display("FAIL rx9d_set: got %b/%h expected 1/01", rx9d_out, rcreg_reg_out); end
    drive_read();
    checks++; if (rx9d_out !== 1'b0) begin errors++; $display("FAIL rx9d_pop: got %b expected 0", rx9d_out); end
`endif
  endtask

  task automatic test_reset_mid();
    drive_push(8'h01, 1'b0);
    drive_push(8'h02, 1'b1);
    drive_push(8'h03, 1'b0);
    checks++; if (oerr_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", oerr_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (count_out !== 4'd0 || oerr_out !== 1'b0 || rcreg_reg_out !== 8'h00 || rx_enable_out !== 1'b1) begin errors++; $display("FAIL rstmid: got cnt=%0d oerr=%b rc=%h rxen=%b expected 0/0/00/1", count_out, oerr_out, rcreg_reg_out, rx_enable_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_oerr_clear();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
